pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard query bundle and the control/counter response.
// The slave side is the hazard controller; the master side drives the ID stage.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              branch_taken;
    logic              cnt_clr;
    logic              stall;
    logic              flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_dest, id_reg_write, id_mem_read,
        output branch_taken, cnt_clr,
        input  stall, flush, fwd_a_sel, fwd_b_sel,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_dest, id_reg_write, id_mem_read,
        input  branch_taken, cnt_clr,
        output stall, flush, fwd_a_sel, fwd_b_sel,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Data/control hazard unit: tracks in-flight producers, raises stall/flush,
// selects EX operand forwarding and counts stall/flush events.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16,
    parameter int FWD_EN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    pipe_hazard_ctrl_if.slave      bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              regWrite;
        logic              memRead;
    } entry_t;

    // WB reads are write-through in the register file, so the entry that
    // retires from MEM is never compared and needs no storage here.
    entry_t exQ;
    entry_t memQ;
    entry_t idEnt;

    logic [1:0]       selAQ;
    logic [1:0]       selBQ;
    logic [CNT_W-1:0] stallCntQ;
    logic [CNT_W-1:0] flushCntQ;

    logic aEx, bEx, aMem, bMem;
    logic hazard, stallW, flushW, issue;
    logic [1:0] selAD, selBD;

    function automatic logic hit(
        input logic              useSrc,
        input logic [REG_AW-1:0] src,
        input entry_t            e
    );
        return useSrc && e.valid && e.regWrite &&
               (e.dest == src) && (src != '0);
    endfunction

    always_comb begin
        idEnt.valid    = 1'b1;
        idEnt.dest     = bus.id_dest;
        idEnt.regWrite = bus.id_reg_write;
        idEnt.memRead  = bus.id_mem_read;

        aEx  = hit(bus.id_use_rs, bus.id_rs, exQ);
        bEx  = hit(bus.id_use_rt, bus.id_rt, exQ);
        aMem = hit(bus.id_use_rs, bus.id_rs, memQ);
        bMem = hit(bus.id_use_rt, bus.id_rt, memQ);

        if (FWD_EN != 0)
            hazard = exQ.memRead && (aEx || bEx);
        else
            hazard = aEx || bEx || aMem || bMem;

        flushW = !reset && bus.branch_taken;
        stallW = !reset && !bus.branch_taken && bus.id_valid && hazard;
        issue  = bus.id_valid && !stallW && !flushW;

        selAD = 2'd0;
        selBD = 2'd0;
        if ((FWD_EN != 0) && issue) begin
            if (aEx && !exQ.memRead) selAD = 2'd1;
            else if (aMem)           selAD = 2'd2;
            if (bEx && !exQ.memRead) selBD = 2'd1;
            else if (bMem)           selBD = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exQ       <= '0;
            memQ      <= '0;
            selAQ     <= 2'd0;
            selBQ     <= 2'd0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            exQ   <= issue ? idEnt : '0;
            memQ  <= flushW ? '0 : exQ;
            selAQ <= selAD;
            selBQ <= selBD;

            if (bus.cnt_clr)
                stallCntQ <= '0;
            else if (stallW && (stallCntQ != '1))
                stallCntQ <= stallCntQ + CNT_W'(1);

            if (bus.cnt_clr)
                flushCntQ <= '0;
            else if (flushW && (flushCntQ != '1))
                flushCntQ <= flushCntQ + CNT_W'(1);
        end
    end

    assign bus.stall     = stallW;
    assign bus.flush     = flushW;
    assign bus.fwd_a_sel = selAQ;
    assign bus.fwd_b_sel = selBQ;
    assign bus.stall_cnt = stallCntQ;
    assign bus.flush_cnt = flushCntQ;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: forwarding, stall-only and 4-bit counter instances
// share one stimulus stream and are checked where each is relevant.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       idValid, useRs, useRt, regWr, memRd, brTaken, cntClr;
    logic [4:0] rs, rt, dest;

    int nVec = 0;
    int nErr = 0;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifF ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifN ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifC ();

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .FWD_EN(1)) dutF (
        .clk(clk), .reset(reset), .bus(ifF));
    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .FWD_EN(0)) dutN (
        .clk(clk), .reset(reset), .bus(ifN));
    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4), .FWD_EN(1)) dutC (
        .clk(clk), .reset(reset), .bus(ifC));

    assign ifF.id_valid = idValid;  assign ifN.id_valid = idValid;
    assign ifC.id_valid = idValid;
    assign ifF.id_rs = rs;  assign ifN.id_rs = rs;  assign ifC.id_rs = rs;
    assign ifF.id_rt = rt;  assign ifN.id_rt = rt;  assign ifC.id_rt = rt;
    assign ifF.id_use_rs = useRs;  assign ifN.id_use_rs = useRs;
    assign ifC.id_use_rs = useRs;
    assign ifF.id_use_rt = useRt;  assign ifN.id_use_rt = useRt;
    assign ifC.id_use_rt = useRt;
    assign ifF.id_dest = dest;  assign ifN.id_dest = dest;
    assign ifC.id_dest = dest;
    assign ifF.id_reg_write = regWr;  assign ifN.id_reg_write = regWr;
    assign ifC.id_reg_write = regWr;
    assign ifF.id_mem_read = memRd;  assign ifN.id_mem_read = memRd;
    assign ifC.id_mem_read = memRd;
    assign ifF.branch_taken = brTaken;  assign ifN.branch_taken = brTaken;
    assign ifC.branch_taken = brTaken;
    assign ifF.cnt_clr = cntClr;  assign ifN.cnt_clr = cntClr;
    assign ifC.cnt_clr = cntClr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic id(input logic v, input logic [4:0] s, input logic [4:0] t,
                      input logic us, input logic ut, input logic [4:0] d,
                      input logic rw, input logic mr);
        idValid = v; rs = s; rt = t; useRs = us; useRt = ut;
        dest = d; regWr = rw; memRd = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        id(0, 0, 0, 0, 0, 0, 0, 0);
        cntClr = 0;
        brTaken = 1;
        // reset holds everything quiet even with a branch request
        tick();
        tick();
        settle();
        chk("rst_flush", 32'(ifF.flush), 0);
        chk("rst_stall", 32'(ifF.stall), 0);
        chk("rst_selA", 32'(ifF.fwd_a_sel), 0);
        chk("rst_selB", 32'(ifF.fwd_b_sel), 0);
        chk("rst_scnt", 32'(ifF.stall_cnt), 0);
        chk("rst_fcnt", 32'(ifF.flush_cnt), 0);
        tick();
        reset = 0;
        brTaken = 0;

        // ALU producer forwarded from EX/MEM
        id(1, 1, 2, 1, 1, 3, 1, 0);
        settle();
        chk("add3_stall", 32'(ifF.stall), 0);
        tick();
        id(1, 3, 0, 1, 1, 6, 1, 0);
        settle();
        chk("dep3_stall", 32'(ifF.stall), 0);
        tick();
        settle();
        chk("dep3_selA", 32'(ifF.fwd_a_sel), 1);
        chk("dep3_selB", 32'(ifF.fwd_b_sel), 0);

        // load-use: one bubble then MEM/WB forward
        tick();
        id(1, 1, 0, 1, 0, 4, 1, 1);
        settle();
        chk("lw4_stall", 32'(ifF.stall), 0);
        tick();
        id(1, 7, 4, 1, 1, 8, 1, 0);
        settle();
        chk("lu_stall", 32'(ifF.stall), 1);
        chk("lu_cnt0", 32'(ifF.stall_cnt), 0);
        tick();
        settle();
        chk("lu_stall2", 32'(ifF.stall), 0);
        chk("lu_cnt1", 32'(ifF.stall_cnt), 1);
        chk("lu_bubSel", 32'(ifF.fwd_b_sel), 0);
        tick();
        settle();
        chk("lu_selB", 32'(ifF.fwd_b_sel), 2);
        chk("lu_selA", 32'(ifF.fwd_a_sel), 0);

        // $0 producer and non-writing producer never match
        tick();
        id(1, 1, 2, 1, 1, 0, 1, 0);
        tick();
        id(1, 0, 0, 1, 1, 9, 1, 0);
        settle();
        chk("r0_stall", 32'(ifF.stall), 0);
        tick();
        settle();
        chk("r0_selA", 32'(ifF.fwd_a_sel), 0);
        chk("r0_selB", 32'(ifF.fwd_b_sel), 0);
        tick();
        id(1, 1, 2, 1, 1, 12, 0, 1);
        tick();
        id(1, 12, 2, 1, 1, 13, 1, 0);
        settle();
        chk("nrw_stall", 32'(ifF.stall), 0);
        tick();
        settle();
        chk("nrw_selA", 32'(ifF.fwd_a_sel), 0);

        // same register in EX and MEM: nearest wins
        tick();
        id(1, 1, 2, 1, 1, 10, 1, 0);
        tick();
        tick();
        id(1, 10, 10, 1, 1, 14, 1, 0);
        settle();
        chk("dup_stall", 32'(ifF.stall), 0);
        tick();
        settle();
        chk("dup_selA", 32'(ifF.fwd_a_sel), 1);
        chk("dup_selB", 32'(ifF.fwd_b_sel), 1);

        // branch over a load-use: flush wins, pipe squashed
        tick();
        id(1, 1, 2, 1, 0, 11, 1, 1);
        tick();
        id(1, 11, 0, 1, 0, 15, 1, 0);
        brTaken = 1;
        settle();
        chk("br_flush", 32'(ifF.flush), 1);
        chk("br_stall", 32'(ifF.stall), 0);
        tick();
        brTaken = 0;
        settle();
        chk("br_flush0", 32'(ifF.flush), 0);
        chk("br_fcnt", 32'(ifF.flush_cnt), 1);
        chk("br_scnt", 32'(ifF.stall_cnt), 1);
        chk("br_exGone", 32'(ifF.stall), 0);
        tick();
        settle();
        chk("br_memGone", 32'(ifF.fwd_a_sel), 0);

        // stall-only instance: two stall cycles, no forwarding
        tick();
        reset = 1;
        id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        settle();
        chk("n_rstSel", 32'(ifN.fwd_a_sel), 0);
        chk("n_rstCnt", 32'(ifN.stall_cnt), 0);
        tick();
        reset = 0;
        id(1, 1, 2, 1, 1, 5, 1, 0);
        settle();
        chk("n_add5", 32'(ifN.stall), 0);
        tick();
        id(1, 5, 0, 1, 0, 16, 1, 0);
        settle();
        chk("n_stall1", 32'(ifN.stall), 1);
        tick();
        settle();
        chk("n_stall2", 32'(ifN.stall), 1);
        tick();
        settle();
        chk("n_issue", 32'(ifN.stall), 0);
        tick();
        settle();
        chk("n_selA", 32'(ifN.fwd_a_sel), 0);
        chk("n_cnt", 32'(ifN.stall_cnt), 2);

        // 4-bit counter: saturation, clear, reset mid-stall
        tick();
        reset = 1;
        tick();
        reset = 0;
        id(1, 1, 0, 1, 0, 1, 1, 1);
        settle();
        chk("c_first", 32'(ifC.stall), 0);
        for (int i = 0; i < 40; i++) tick();
        settle();
        chk("c_sat", 32'(ifC.stall_cnt), 15);
        tick();
        settle();
        chk("c_preClr", 32'(ifC.stall), 1);
        cntClr = 1;
        tick();
        cntClr = 0;
        settle();
        chk("c_clr", 32'(ifC.stall_cnt), 0);
        tick();
        settle();
        chk("c_preRst", 32'(ifC.stall), 1);
        reset = 1;
        #1;
        chk("c_rstStall", 32'(ifC.stall), 0);
        tick();
        settle();
        chk("c_rstScnt", 32'(ifC.stall_cnt), 0);
        chk("c_rstFcnt", 32'(ifC.flush_cnt), 0);
        chk("c_rstSelA", 32'(ifC.fwd_a_sel), 0);
        chk("c_rstSelB", 32'(ifC.fwd_b_sel), 0);
        tick();
        reset = 0;
        settle();
        chk("c_postRst", 32'(ifC.stall), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
